seq_restoring_divider: RTL

//   Multi-cycle unsigned integer divider: QUOTIENT = A / B, REMAINDER = A % B.

---
 rtl/seq_restoring_divider_if.sv | 25 ++
 rtl/seq_restoring_divider.sv | 109 ++++++++++
 2 files changed

// File: rtl/seq_restoring_divider_if.sv
// Start/done handshake bus between an issuing controller and the divider.
interface seq_restoring_divider_if #(
  parameter int WIDTH = 6
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  // Controller side: issues operands, observes status and results.
  modport master (
    output start, a, b,
    input  busy, done, quotient, remainder, div_by_zero
  );

  // Divider side.
  modport slave (
    input  start, a, b,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock.
// IDLE -> RUN (WIDTH steps) -> FIN (one-cycle DONE); divide-by-zero skips RUN.
module seq_restoring_divider #(
  parameter int WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seq_restoring_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;      // dividend shifts out, quotient bits shift in
  logic [WIDTH-1:0] d_q, d_d;      // latched divisor
  logic [WIDTH:0]   r_q, r_d;      // partial remainder, one guard bit for the borrow
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   t_step, s_step, r_step;
  logic [WIDTH-1:0] q_step;

  // One restoring step: trial subtract, keep it only when no borrow.
  always_comb begin
    t_step = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    s_step = t_step + ~{1'b0, d_q} + {{WIDTH{1'b0}}, 1'b1};
    q_step = {q_q[WIDTH-2:0], ~s_step[WIDTH]};
    r_step = s_step[WIDTH] ? t_step : s_step;
  end

  // Next-state and result-register logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE, S_FIN: begin
        if (bus.start) begin
          q_d   = bus.a;
          d_d   = bus.b;
          r_d   = '0;
          cnt_d = CW'(WIDTH);
          if (bus.b == '0) begin
            // Zero divisor: report immediately, no iterations.
            state_d = S_FIN;
            quo_d   = '1;
            rem_d   = bus.a;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        q_d   = q_step;
        r_d   = r_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_FIN;
          quo_d   = q_step;
          rem_d   = r_step[WIDTH-1:0];
          dbz_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy        = (state_q == S_RUN);
  assign bus.done        = (state_q == S_FIN);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
endmodule
